// File: rtl/fp_to_int_conv.sv
// fp_to_int_conv: three-stage pipelined float-to-signed-integer converter.
// The floating-point word is {sign, exp, man}. The exponent is biased and the
// mantissa has an implicit leading one. Results that are out of range or
// infinite saturate. A NaN input produces the most positive integer and
// raises Invalid_o. Denormal inputs flush to zero.
//
// Optional feature: define FP_TO_INT_ROUND_NEAREST_EN to round to nearest,
// ties to even. When the macro is undefined, the result is truncated toward
// zero.
//
// Ports:
//   Clk_i         clock
//   RstN_i        asynchronous reset, active low
//   InData_i      FP word {sign, exp, man}
//   InDataVal_i   InData_i valid this cycle
//   OutData_o     signed integer result
//   OutDataVal_o  OutData_o valid (3 cycles after the input is accepted)
//   Overflow_o    result saturated (finite out-of-range or Inf)
//   Invalid_o     input was NaN
module fp_to_int_conv #(
    parameter int unsigned OutWidth = 32,
    parameter int unsigned ExpWidth = 8,
    parameter int unsigned ManWidth = 23,
    parameter int unsigned ExpBias  = 127
) (
    input  logic                         Clk_i,
    input  logic                         RstN_i,
    input  logic [ExpWidth+ManWidth:0]   InData_i,
    input  logic                         InDataVal_i,
    output logic [OutWidth-1:0]          OutData_o,
    output logic                         OutDataVal_o,
    output logic                         Overflow_o,
    output logic                         Invalid_o
);

    localparam int unsigned InWidth  = 1 + ExpWidth + ManWidth;
    localparam int unsigned MagWidth = ((OutWidth > ManWidth + 1) ? OutWidth : ManWidth + 1) + 1;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    localparam int unsigned GuardW   = 1;
`else
    localparam int unsigned GuardW   = 0;
`endif
    localparam int unsigned VecWidth   = MagWidth + GuardW;
    localparam int unsigned ShWidth    = $clog2(VecWidth + 1);
    // A right shift this large pushes every mantissa bit below the guard position.
    localparam int unsigned RightClamp = ManWidth + 2;

    localparam logic [MagWidth-1:0] PosLimit = MagWidth'((64'd1 << (OutWidth - 1)) - 64'd1);
    localparam logic [MagWidth-1:0] NegLimit = MagWidth'(64'd1 << (OutWidth - 1));
    localparam logic [OutWidth-1:0] MaxPos   = OutWidth'((64'd1 << (OutWidth - 1)) - 64'd1);
    localparam logic [OutWidth-1:0] MinNeg   = ~MaxPos;

    typedef enum logic [2:0] {
        ClsZero,
        ClsNan,
        ClsInf,
        ClsSmall,
        ClsOvf,
        ClsNormal
    } fpClass_t;

    // ---------------- Stage 1: unpack and classify ----------------
    logic                inSign;
    logic [ExpWidth-1:0] inExp;
    logic [ManWidth-1:0] inMan;
    int                  inE;
    fpClass_t            inCls;

    assign inSign = InData_i[InWidth-1];
    assign inExp  = InData_i[ExpWidth+ManWidth-1:ManWidth];
    assign inMan  = InData_i[ManWidth-1:0];

    always_comb begin
        inE   = int'(inExp) - int'(ExpBias);
        inCls = ClsNormal;
        if (inExp == '0) begin
            inCls = ClsZero;
        end else if (&inExp) begin
            inCls = (inMan != '0) ? ClsNan : ClsInf;
        end else if (inE < 0) begin
            inCls = ClsSmall;
        end else if ((inE > int'(OutWidth) - 1) ||
                     ((inE == int'(OutWidth) - 1) && (!inSign || (inMan != '0)))) begin
            // Only the exact most-negative value survives at e == OutWidth-1.
            inCls = ClsOvf;
        end
    end

    logic                       s1Val;
    logic                       s1Sign;
    logic [ManWidth:0]          s1Man;
    logic signed [ExpWidth:0]   s1Exp;
    fpClass_t                   s1Cls;

    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            s1Val  <= 1'b0;
            s1Sign <= 1'b0;
            s1Man  <= '0;
            s1Exp  <= '0;
            s1Cls  <= ClsZero;
        end else begin
            s1Val <= InDataVal_i;
            if (InDataVal_i) begin
                s1Sign <= inSign;
                s1Man  <= {1'b1, inMan};
                s1Exp  <= (ExpWidth + 1)'(inE);
                s1Cls  <= inCls;
            end
        end
    end

    // ---------------- Stage 2: log2-stage barrel shift ----------------
    int                  s1E;
    logic                shLeft;
    logic [ShWidth-1:0]  shAmt;
    logic [VecWidth-1:0] shVec;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    logic                shSticky;
`endif

    always_comb begin
        s1E    = int'(s1Exp);
        shLeft = 1'b0;
        shAmt  = '0;
        if (s1E >= int'(ManWidth)) begin
            shLeft = 1'b1;
            shAmt  = ShWidth'(s1E - int'(ManWidth));
        end else if (int'(ManWidth) - s1E > int'(RightClamp)) begin
            shAmt  = ShWidth'(RightClamp);
        end else begin
            shAmt  = ShWidth'(int'(ManWidth) - s1E);
        end

        // The mantissa starts one position up when a guard bit is kept below the LSB.
        shVec = VecWidth'(s1Man) << GuardW;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
        shSticky = 1'b0;
`endif
        for (int k = 0; k < int'(ShWidth); k++) begin
            if (shAmt[k]) begin
                if (shLeft) begin
                    shVec = shVec << (1 << k);
                end else begin
`ifdef FP_TO_INT_ROUND_NEAREST_EN
                    // Bits dropped here lie below the new guard position.
                    for (int b = 0; b < int'(VecWidth); b++) begin
                        if (b < (1 << k)) begin
                            shSticky = shSticky | shVec[b];
                        end
                    end
`endif
                    shVec = shVec >> (1 << k);
                end
            end
        end
    end

    logic                s2Val;
    logic                s2Sign;
    fpClass_t            s2Cls;
    logic [MagWidth-1:0] s2Mag;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    logic                s2Guard;
    logic                s2Sticky;
`endif

    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            s2Val    <= 1'b0;
            s2Sign   <= 1'b0;
            s2Cls    <= ClsZero;
            s2Mag    <= '0;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
            s2Guard  <= 1'b0;
            s2Sticky <= 1'b0;
`endif
        end else begin
            s2Val <= s1Val;
            if (s1Val) begin
                s2Sign   <= s1Sign;
                s2Cls    <= s1Cls;
                s2Mag    <= shVec[VecWidth-1:GuardW];
`ifdef FP_TO_INT_ROUND_NEAREST_EN
                s2Guard  <= shVec[0];
                s2Sticky <= shSticky;
`endif
            end
        end
    end

    // ---------------- Stage 3: round, negate, saturate ----------------
    logic [MagWidth-1:0] rndMag;
    logic                rangeOvf;
    logic [OutWidth-1:0] resData;
    logic                resOvf;
    logic                resInv;

    always_comb begin
        rndMag = s2Mag;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
        rndMag = s2Mag + MagWidth'(s2Guard & (s2Sticky | s2Mag[0]));
`endif
        // A rounding carry can push a finite value past the representable range.
        rangeOvf = s2Sign ? (rndMag > NegLimit) : (rndMag > PosLimit);
        resData  = '0;
        resOvf   = 1'b0;
        resInv   = 1'b0;
        case (s2Cls)
            ClsNan: begin
                resData = MaxPos;
                resInv  = 1'b1;
            end
            ClsInf, ClsOvf: begin
                resData = s2Sign ? MinNeg : MaxPos;
                resOvf  = 1'b1;
            end
`ifdef FP_TO_INT_ROUND_NEAREST_EN
            ClsNormal, ClsSmall: begin
`else
            ClsNormal: begin
`endif
                if (rangeOvf) begin
                    resData = s2Sign ? MinNeg : MaxPos;
                    resOvf  = 1'b1;
                end else begin
                    resData = s2Sign ? OutWidth'(-rndMag) : OutWidth'(rndMag);
                end
            end
            default: begin
                resData = '0;
            end
        endcase
    end

    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            OutDataVal_o <= 1'b0;
            OutData_o    <= '0;
            Overflow_o   <= 1'b0;
            Invalid_o    <= 1'b0;
        end else begin
            OutDataVal_o <= s2Val;
            if (s2Val) begin
                OutData_o  <= resData;
                Overflow_o <= resOvf;
                Invalid_o  <= resInv;
            end
        end
    end

endmodule

// File: doc/fp_to_int_conv.md
Name: fp_to_int_conv

Overview:
- Pipelined converter from a custom-format floating-point word (sign, exponent, mantissa) to a two's-complement signed integer.
- Inverse of the integer-to-float path; sits on the same valid-qualified datapath streams.
- Converts one word per clock with fixed latency and saturates out-of-range inputs.
- Drives overflow and invalid status flags alongside the data.

Parameters:
- OutWidth, 32, integer output width.
- ExpWidth, 8, exponent field width.
- ManWidth, 23, stored mantissa field width (hidden bit implicit).
- ExpBias, 127, exponent bias.

Ports:
- Clk_i  input  1  clock.
- RstN_i  input  1  asynchronous reset, active low.
- InData_i  input  1+ExpWidth+ManWidth  FP word {sign, exp, man}.
- InDataVal_i  input  1  InData_i valid this cycle.
- OutData_o  output  OutWidth  signed integer result.
- OutDataVal_o  output  1  OutData_o valid.
- Overflow_o  output  1  result saturated (finite out-of-range or Inf); qualified by OutDataVal_o.
- Invalid_o  output  1  input was NaN; qualified by OutDataVal_o.

Behaviour:
- Clocking: one clock (Clk_i). Reset is asynchronous and active-low (RstN_i).
- Reset: all pipeline registers, OutData_o, OutDataVal_o, Overflow_o and Invalid_o clear to 0.
- Reset asserted mid-operation discards all in-flight words; no valid output appears until new inputs arrive.
- Handshake: valid-only, no backpressure.
  - Every cycle with InDataVal_i=1 is accepted.
  - The valid bit shifts through all stages every cycle.
  - Data, Overflow_o and Invalid_o registers load only when their stage valid is 1; otherwise they hold their previous value.
  - Back-to-back valids give back-to-back outputs.
- Latency: exactly 3 cycles from the InDataVal_i sample edge to OutDataVal_o high.
- Stage 1, unpack and classify:
  - Register sign and mantissa {1, man}.
  - Compute e = exp - ExpBias as a signed value of ExpWidth+1 bits.
  - Classes:
    - exp==0: zero (denormals flush to 0, no flags).
    - exp all ones, man!=0: NaN.
    - exp all ones, man==0: Inf.
    - e<0: magnitude below 1.
    - e>OutWidth-1, or e==OutWidth-1 with (sign==0 or man!=0): overflow.
    - Otherwise: normal.
- Stage 2, log2-stage barrel shift of {1, man}:
  - Left shift by e-ManWidth when e>=ManWidth; right shift by ManWidth-e otherwise.
  - Keep a guard bit and a sticky bit (OR of all bits shifted out) for rounding.
  - Internal magnitude width is max(OutWidth, ManWidth+1)+1.
- Stage 3, round, negate and saturate:
  - Default rounding is truncation toward zero.
  - Negate the magnitude when sign=1.
  - Overflow or Inf: output 2^(OutWidth-1)-1 if sign=0, -2^(OutWidth-1) if sign=1; Overflow_o=1.
  - NaN: output 2^(OutWidth-1)-1, Invalid_o=1, Overflow_o=0.
  - Exact -2^(OutWidth-1) (sign=1, e==OutWidth-1, man==0) is representable: output 0x80..0, no flag.
  - Zero and magnitude below 1: output 0, both flags 0 (under truncation).
  - -0.0 gives 0.
- Flags are mutually exclusive.

Optional Feature:
- Macro: FP_TO_INT_ROUND_NEAREST_EN.
- Defined: stage 3 rounds to nearest, ties to even, using the guard and sticky bits plus the result LSB.
  - A rounding carry that exceeds the representable range saturates and sets Overflow_o.
  - Inputs with e==-1 (0.5 <= |x| < 1) round to 0 or ±1.
  - Latency is unchanged at 3 cycles.
- Undefined: truncation toward zero; the guard and sticky logic is removed.

Test Plan:
- Reset: hold RstN_i=0, drive InDataVal_i=1 -> all outputs 0. Release, then apply 0x3FC00000 (1.5) -> 3 cycles later OutDataVal_o=1, OutData_o=0x00000001, flags 0.
- Signed stream: back-to-back 0xC2F6E979 (-123.456), 0x00000000, 0xBF400000 (-0.75) on consecutive cycles -> outputs 0xFFFFFF85, 0x00000000, 0x00000000 on three consecutive cycles.
- Saturation:
  - 0x4F000000 (2^31) -> 0x7FFFFFFF, Overflow_o=1.
  - 0xCF000000 (-2^31) -> 0x80000000, Overflow_o=0.
  - 0xFF800000 (-Inf) -> 0x80000000, Overflow_o=1.
- NaN: 0x7FC00000 -> 0x7FFFFFFF, Invalid_o=1, Overflow_o=0.
- Hold and reset: a gap in valid keeps OutData_o unchanged with OutDataVal_o=0. Pulse RstN_i low while 2 words are in flight -> no OutDataVal_o for those words.
- With FP_TO_INT_ROUND_NEAREST_EN:
  - 0x40200000 (2.5) -> 2.
  - 0x40600000 (3.5) -> 4.
  - 0xBF400000 (-0.75) -> 0xFFFFFFFF.
  - 0x3F000000 (0.5) -> 0.
